gpo_mailbox_rx: RTL and testbench

GPO_MAILBOX_RX -- requirements
Module: gpo_mailbox_rx

---
 rtl/gpo_mailbox_pkg.sv | 18 +
 rtl/mbox_fifo.sv | 48 ++++
 rtl/gpo_mailbox_rx.sv | 88 ++++++++
 tb/tb_gpo_mailbox_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpo_mailbox_pkg.sv
// gpo_mailbox_pkg: field positions and constants shared by the GPO mailbox receiver.
package gpo_mailbox_pkg;
  localparam int STROBE_BIT = 31;
  localparam int CMD_MSB = 30;
  localparam int CMD_LSB = 24;
  localparam int CMD_W = CMD_MSB - CMD_LSB + 1;
  localparam int PAYLOAD_W = 24;
  localparam logic [CMD_W-1:0] CMD_CLR_OVF = 7'h7F;
  localparam int GPI_ACK_BIT = 31;
  localparam int GPI_OVF_BIT = 30;
  localparam int GPI_LVL_MSB = 22;
  localparam int GPI_LVL_LSB = 16;
  localparam int GPI_LVL_W = GPI_LVL_MSB - GPI_LVL_LSB + 1;
  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [PAYLOAD_W-1:0] payload;
  } mbox_msg_t;
endpackage

// File: rtl/mbox_fifo.sv
// mbox_fifo: synchronous FIFO with level output; head is presented from storage, zeroed when empty.
module mbox_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    empty = lvl_q == '0;
    full = lvl_q == LW'(DEPTH);
    do_pop = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = wdata;
    wp_d = wp_q + AW'(do_push);
    rp_d = rp_q + AW'(do_pop);
    lvl_d = lvl_q + LW'(do_push) - LW'(do_pop);
    rdata = empty ? '0 : mem_q[rp_q];
    level = lvl_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      lvl_q <= lvl_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/gpo_mailbox_rx.sv
// gpo_mailbox_rx: decodes toggle-strobed CPU mailbox words into a timestamped FIFO.
// Define GPO_MAILBOX_TS_EN to build the timestamp counter; otherwise rd_ts is constant 0.
module gpo_mailbox_rx
  import gpo_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                 XCLK,
  input  logic                 XRESET_N,
  input  logic [31:0]          XGPO,
  output logic [31:0]          XGPI,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [CMD_W-1:0]     rd_cmd,
  output logic [PAYLOAD_W-1:0] rd_data,
  output logic [TS_WIDTH-1:0]  rd_ts
);
`ifdef GPO_MAILBOX_TS_EN
  localparam int TSW = TS_WIDTH;
`else
  localparam int TSW = 0;
`endif
  localparam int EW = CMD_W + PAYLOAD_W + TSW;
  logic [31:0] gpo_q, gpo_d;
  logic strb_q, strb_d, ack_q, ack_d, ovf_q, ovf_d;
  logic evt, clr, push, pop, full, empty;
  logic [$clog2(DEPTH):0] level;
  logic [EW-1:0] wdata, rdata;
  mbox_msg_t msg;
  always_comb begin
    gpo_d = XGPO;
    strb_d = gpo_q[STROBE_BIT];
    msg = mbox_msg_t'(gpo_q[CMD_MSB:0]);
    evt = gpo_q[STROBE_BIT] ^ strb_q;
    clr = evt && msg.cmd == CMD_CLR_OVF;
    push = evt && !clr;
    pop = !empty && rd_ready;
    ack_d = ack_q ^ evt;
    ovf_d = clr ? 1'b0 : (push && full && !pop) ? 1'b1 : ovf_q;
    XGPI = '0;
    XGPI[GPI_ACK_BIT] = ack_q;
    XGPI[GPI_OVF_BIT] = ovf_q;
    XGPI[GPI_LVL_MSB:GPI_LVL_LSB] = GPI_LVL_W'(level);
    rd_valid = !empty;
    rd_cmd = rdata[EW-1 -: CMD_W];
    rd_data = rdata[EW-1-CMD_W -: PAYLOAD_W];
  end
`ifdef GPO_MAILBOX_TS_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  always_comb begin
    ts_d = ts_q + TS_WIDTH'(1);
    wdata = {msg, ts_q};
    rd_ts = rdata[TS_WIDTH-1:0];
  end
  always_ff @(posedge XCLK or negedge XRESET_N)
    if (!XRESET_N) ts_q <= '0;
    else ts_q <= ts_d;
`else
  always_comb begin
    wdata = msg;
    rd_ts = '0;
  end
`endif
  always_ff @(posedge XCLK or negedge XRESET_N)
    if (!XRESET_N) begin
      gpo_q <= '0;
      strb_q <= 1'b0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      gpo_q <= gpo_d;
      strb_q <= strb_d;
      ack_q <= ack_d;
      ovf_q <= ovf_d;
    end
  mbox_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(XCLK),
    .rst_n(XRESET_N),
    .push(push),
    .wdata(wdata),
    .pop(pop),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .level(level)
  );
endmodule

// File: tb/tb_gpo_mailbox_rx.sv
// tb_gpo_mailbox_rx: scoreboard bench for gpo_mailbox_rx (DEPTH=8, TS_WIDTH=4).
module tb_gpo_mailbox_rx;
  logic XCLK = 0;
  logic XRESET_N = 0;
  logic [31:0] XGPO = '0;
  logic [31:0] XGPI;
  logic rd_valid;
  logic rd_ready = 0;
  logic [6:0] rd_cmd;
  logic [23:0] rd_data;
  logic [3:0] rd_ts;
  int n_vec = 0;
  int n_err = 0;
  logic strb = 0;
  logic exp_ack = 0;
  logic exp_ovf = 0;
  logic [30:0] q[$];

  gpo_mailbox_rx #(.DEPTH(8), .TS_WIDTH(4)) dut (
    .XCLK(XCLK), .XRESET_N(XRESET_N), .XGPO(XGPO), .XGPI(XGPI),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_cmd(rd_cmd),
    .rd_data(rd_data), .rd_ts(rd_ts)
  );

  always #5 XCLK = ~XCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] exp_gpi();
    return {exp_ack, exp_ovf, 7'b0, 7'(q.size()), 16'b0};
  endfunction

  task automatic send(input logic [6:0] cmd, input logic [23:0] pl);
    strb = ~strb;
    XGPO = {strb, cmd, pl};
    exp_ack = ~exp_ack;
    if (cmd == 7'h7F) exp_ovf = 0;
    else if (q.size() < 8) q.push_back({cmd, pl});
    else exp_ovf = 1;
    @(posedge XCLK);
    @(posedge XCLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (XGPI !== 32'h0 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: XGPI=%h rd_valid=%b want 0/0", XGPI, rd_valid);
    end
    @(posedge XCLK);
    #1;
    n_vec++;
    if ({rd_cmd, rd_data, rd_ts} !== 35'h0) begin
      n_err++;
      $display("FAIL reset_head: cmd=%h data=%h ts=%h want 0", rd_cmd, rd_data, rd_ts);
    end
    XRESET_N = 1;
    @(posedge XCLK);
    #1;
  endtask

  task automatic test_drain(input int exp_n);
    int got = 0;
    logic [30:0] e;
    rd_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (!rd_valid) break;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL drain_extra: unexpected head cmd=%h data=%h", rd_cmd, rd_data);
      end else begin
        e = q.pop_front();
        if ({rd_cmd, rd_data} !== e) begin
          n_err++;
          $display("FAIL drain_head: got %h/%h want %h/%h", rd_cmd, rd_data, e[30:24], e[23:0]);
        end
      end
      got++;
      @(posedge XCLK);
      #1;
    end
    rd_ready = 0;
    n_vec++;
    if (got != exp_n || rd_valid !== 1'b0 || XGPI !== exp_gpi()) begin
      n_err++;
      $display("FAIL drain_end: popped %0d want %0d, rd_valid=%b, XGPI=%h want %h",
               got, exp_n, rd_valid, XGPI, exp_gpi());
    end
  endtask

  task automatic test_single();
    XGPO = 32'h8512_3456;
    strb = 1;
    exp_ack = 1;
    q.push_back({7'h05, 24'h123456});
    @(posedge XCLK);
    #1;
    n_vec++;
    if (rd_valid !== 1'b0 || XGPI !== 32'h0) begin
      n_err++;
      $display("FAIL single_early: rd_valid=%b XGPI=%h want 0/0", rd_valid, XGPI);
    end
    @(posedge XCLK);
    #1;
    n_vec++;
    if (rd_valid !== 1'b1 || rd_cmd !== 7'h05 || rd_data !== 24'h123456) begin
      n_err++;
      $display("FAIL single_head: valid=%b cmd=%h data=%h want 1/05/123456", rd_valid, rd_cmd, rd_data);
    end
    n_vec++;
    if (XGPI !== 32'h8001_0000) begin
      n_err++;
      $display("FAIL single_gpi: XGPI=%h want 80010000", XGPI);
    end
    test_drain(1);
  endtask

  task automatic test_overflow_clear();
    for (int i = 0; i < 9; i++) send(7'(16 + i), 24'(256 + i));
    n_vec++;
    if (XGPI !== exp_gpi() || XGPI[30] !== 1'b1 || XGPI[22:16] !== 7'd8) begin
      n_err++;
      $display("FAIL overflow_gpi: XGPI=%h want %h", XGPI, exp_gpi());
    end
    send(7'h7F, 24'h0);
    n_vec++;
    if (XGPI !== exp_gpi() || XGPI[30] !== 1'b0 || XGPI[22:16] !== 7'd8) begin
      n_err++;
      $display("FAIL clear_gpi: XGPI=%h want %h", XGPI, exp_gpi());
    end
  endtask

  task automatic test_full_pop();
    strb = ~strb;
    XGPO = {strb, 7'h2A, 24'hCAFE00};
    exp_ack = ~exp_ack;
    @(posedge XCLK);
    #1;
    rd_ready = 1;
    n_vec++;
    if ({rd_cmd, rd_data} !== q[0]) begin
      n_err++;
      $display("FAIL fullpop_head: got %h/%h want %h", rd_cmd, rd_data, q[0]);
    end
    void'(q.pop_front());
    q.push_back({7'h2A, 24'hCAFE00});
    @(posedge XCLK);
    #1;
    rd_ready = 0;
    n_vec++;
    if (XGPI !== exp_gpi() || XGPI[22:16] !== 7'd8) begin
      n_err++;
      $display("FAIL fullpop_gpi: XGPI=%h want %h", XGPI, exp_gpi());
    end
    test_drain(8);
  endtask

  task automatic test_timestamp();
    logic [3:0] ts_a, ts_b, d;
    send(7'h31, 24'h00AAAA);
    repeat (18) @(posedge XCLK);
    #1;
    send(7'h32, 24'h00BBBB);
    ts_a = rd_ts;
    n_vec++;
    if (rd_cmd !== 7'h31 || rd_data !== 24'h00AAAA) begin
      n_err++;
      $display("FAIL ts_head_a: got %h/%h want 31/00aaaa", rd_cmd, rd_data);
    end
    rd_ready = 1;
    @(posedge XCLK);
    #1;
    void'(q.pop_front());
    ts_b = rd_ts;
    n_vec++;
    if (rd_cmd !== 7'h32 || rd_data !== 24'h00BBBB) begin
      n_err++;
      $display("FAIL ts_head_b: got %h/%h want 32/00bbbb", rd_cmd, rd_data);
    end
    @(posedge XCLK);
    #1;
    rd_ready = 0;
    void'(q.pop_front());
    d = ts_b - ts_a;
    n_vec++;
`ifdef GPO_MAILBOX_TS_EN
    if (d !== 4'd4) begin
      n_err++;
      $display("FAIL ts_delta: got %0d (a=%0d b=%0d) want 4", d, ts_a, ts_b);
    end
`else
    if (ts_a !== 4'd0 || ts_b !== 4'd0) begin
      n_err++;
      $display("FAIL ts_zero: a=%0d b=%0d delta=%0d want 0", ts_a, ts_b, d);
    end
`endif
    n_vec++;
    if (rd_valid !== 1'b0 || XGPI !== exp_gpi()) begin
      n_err++;
      $display("FAIL ts_empty: rd_valid=%b XGPI=%h want 0/%h", rd_valid, XGPI, exp_gpi());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) send(7'(64 + i), 24'(4096 + i));
    n_vec++;
    if (XGPI !== exp_gpi() || XGPI[22:16] !== 7'd3) begin
      n_err++;
      $display("FAIL areset_fill: XGPI=%h want %h", XGPI, exp_gpi());
    end
    @(posedge XCLK);
    #3;
    XRESET_N = 0;
    #1;
    n_vec++;
    if (XGPI !== 32'h0 || rd_valid !== 1'b0 || {rd_cmd, rd_data, rd_ts} !== 35'h0) begin
      n_err++;
      $display("FAIL areset_now: XGPI=%h valid=%b head=%h/%h/%h want all 0",
               XGPI, rd_valid, rd_cmd, rd_data, rd_ts);
    end
    q.delete();
    exp_ack = 0;
    exp_ovf = 0;
    strb = 1;
    XGPO = {1'b1, 7'h11, 24'hABCDEF};
    @(posedge XCLK);
    #1;
    XRESET_N = 1;
    exp_ack = 1;
    q.push_back({7'h11, 24'hABCDEF});
    @(posedge XCLK);
    @(posedge XCLK);
    #1;
    n_vec++;
    if (XGPI !== exp_gpi() || rd_cmd !== 7'h11 || rd_data !== 24'hABCDEF) begin
      n_err++;
      $display("FAIL areset_event: XGPI=%h head=%h/%h want %h 11/abcdef", XGPI, rd_cmd, rd_data, exp_gpi());
    end
    repeat (4) @(posedge XCLK);
    #1;
    n_vec++;
    if (XGPI !== exp_gpi()) begin
      n_err++;
      $display("FAIL areset_once: XGPI=%h want %h", XGPI, exp_gpi());
    end
    test_drain(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow_clear();
    test_full_pop();
    test_timestamp();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
